// File: rtl/tetris_pkg.sv
// Shared types for the tetris datapath: commands, shape codes, board size defaults,
// board cell coordinates and the piece_mover FSM state encoding.
package tetris_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;

  typedef enum logic [1:0] {
    CMD_LEFT   = 2'd0,
    CMD_RIGHT  = 2'd1,
    CMD_DOWN   = 2'd2,
    CMD_ROTATE = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    SHAPE_I = 3'd0,
    SHAPE_O = 3'd1,
    SHAPE_T = 3'd2,
    SHAPE_S = 3'd3,
    SHAPE_Z = 3'd4,
    SHAPE_J = 3'd5,
    SHAPE_L = 3'd6
  } shape_e;

  typedef struct packed {
    logic [4:0] x;
    logic [5:0] y;
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_PROBE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } mover_state_e;

endpackage

// File: rtl/piece_transform.sv
// Combinational move/rotate of the four piece cells plus a horizontal kick offset.
// Targets are evaluated as 7-bit signed values so that off-board results are detectable.
module piece_transform
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic [19:0] cur_x_i,
  input  logic [23:0] cur_y_i,
  input  logic [1:0]  cmd_i,
  input  logic [2:0]  shape_i,
  input  logic [1:0]  kick_i,
  output logic [19:0] tgt_x_o,
  output logic [23:0] tgt_y_o,
  output logic        oob_o
);

  localparam logic signed [6:0] XLIM = 7'(BOARD_W);
  localparam logic signed [6:0] YLIM = 7'(BOARD_H);

  always_comb begin
    logic signed [6:0] px, py, kx, cx, cy, nx, ny;
    tgt_x_o = '0;
    tgt_y_o = '0;
    oob_o   = 1'b0;
    // Cell 1 is the rotation pivot; kick_i is a 2-bit two's complement column shift.
    px = signed'({2'b00, cur_x_i[9:5]});
    py = signed'({1'b0, cur_y_i[11:6]});
    kx = signed'({{5{kick_i[1]}}, kick_i});
    cx = '0;
    cy = '0;
    nx = '0;
    ny = '0;
    for (int k = 0; k < 4; k++) begin
      cx = signed'({2'b00, cur_x_i[5*k +: 5]});
      cy = signed'({1'b0, cur_y_i[6*k +: 6]});
      nx = cx;
      ny = cy;
      case (cmd_i)
        CMD_LEFT:  nx = cx - 7'sd1;
        CMD_RIGHT: nx = cx + 7'sd1;
        CMD_DOWN:  ny = cy + 7'sd1;
        default: begin
          if (shape_i != SHAPE_O) begin
            nx = px - (cy - py);
            ny = py + (cx - px);
          end
        end
      endcase
      nx = nx + kx;
      if ((nx < 7'sd0) || (nx >= XLIM) || (ny < 7'sd0) || (ny >= YLIM)) begin
        oob_o = 1'b1;
      end
      tgt_x_o[5*k +: 5] = nx[4:0];
      tgt_y_o[6*k +: 6] = ny[5:0];
    end
  end

endmodule

// File: rtl/piece_mover.sv
// Evaluates one move/rotate request: target calculation, bounds check, then a
// fixed-latency occupancy probe of the four target cells. Optional: WALL_KICK_EN.
module piece_mover
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic [2:0] shape,
  input  logic [4:0] cur_x0,
  input  logic [4:0] cur_x1,
  input  logic [4:0] cur_x2,
  input  logic [4:0] cur_x3,
  input  logic [5:0] cur_y0,
  input  logic [5:0] cur_y1,
  input  logic [5:0] cur_y2,
  input  logic [5:0] cur_y3,
  output logic [4:0] rd_x,
  output logic [5:0] rd_y,
  input  logic       rd_occ,
  output logic       done,
  output logic       canmove,
  output logic       blocked_down,
  output logic [4:0] new_x0,
  output logic [4:0] new_x1,
  output logic [4:0] new_x2,
  output logic [4:0] new_x3,
  output logic [5:0] new_y0,
  output logic [5:0] new_y1,
  output logic [5:0] new_y2,
  output logic [5:0] new_y3
);

  mover_state_e state_q, state_d;
  cmd_e         cmd_q;
  logic [2:0]   shape_q;
  logic [19:0]  cur_x_q, tgt_x_q, new_x_q, new_x_d, tx_c, cand_x;
  logic [23:0]  cur_y_q, tgt_y_q, new_y_q, new_y_d, ty_c, cand_y;
  logic [1:0]   k_q, k_d;
  logic         fail_q, fail_d;
  logic         canmove_q, canmove_d;
  cell_t        rd_q, rd_d;
  logic [1:0]   kick_off;
  logic         oob, accept, att_end, att_fail;

`ifdef WALL_KICK_EN
  logic [1:0]  kick_q, kick_d;
  logic [19:0] base_x_q;
  logic [23:0] base_y_q;

  // Retry order: unshifted, then x-1, then x+1.
  always_comb begin
    case (kick_q)
      2'd1:    kick_off = 2'b11;
      2'd2:    kick_off = 2'b01;
      default: kick_off = 2'b00;
    endcase
  end
`else
  assign kick_off = 2'b00;
`endif

  piece_transform #(
    .BOARD_W(BOARD_W),
    .BOARD_H(BOARD_H)
  ) u_transform (
    .cur_x_i (cur_x_q),
    .cur_y_i (cur_y_q),
    .cmd_i   (cmd_q),
    .shape_i (shape_q),
    .kick_i  (kick_off),
    .tgt_x_o (tx_c),
    .tgt_y_o (ty_c),
    .oob_o   (oob)
  );

  assign accept = (state_q == ST_IDLE) && cmd_valid;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    fail_d    = fail_q;
    canmove_d = canmove_q;
    rd_d      = rd_q;
    new_x_d   = new_x_q;
    new_y_d   = new_y_q;
    att_end   = 1'b0;
    att_fail  = 1'b0;
    cand_x    = tgt_x_q;
    cand_y    = tgt_y_q;
`ifdef WALL_KICK_EN
    kick_d    = kick_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CALC;
`ifdef WALL_KICK_EN
          kick_d  = 2'd0;
`endif
        end
      end
      ST_CALC: begin
        fail_d = 1'b0;
        k_d    = 2'd0;
        if (oob) begin
          att_end  = 1'b1;
          att_fail = 1'b1;
          cand_x   = tx_c;
          cand_y   = ty_c;
        end else begin
          rd_d.x  = tx_c[4:0];
          rd_d.y  = ty_c[5:0];
          state_d = ST_PROBE;
        end
      end
      ST_PROBE: begin
        // rd_occ lags the address by one cycle, so probe k sees cell k-1.
        if ((k_q != 2'd0) && rd_occ) fail_d = 1'b1;
        if (k_q == 2'd3) begin
          state_d = ST_WAIT;
        end else begin
          k_d    = k_q + 2'd1;
          rd_d.x = tgt_x_q[5*k_d +: 5];
          rd_d.y = tgt_y_q[6*k_d +: 6];
        end
      end
      ST_WAIT: begin
        att_end  = 1'b1;
        att_fail = fail_q | rd_occ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (att_end) begin
`ifdef WALL_KICK_EN
      if (att_fail && (cmd_q == CMD_ROTATE) && (kick_q != 2'd2)) begin
        kick_d  = kick_q + 2'd1;
        state_d = ST_CALC;
      end else begin
        state_d   = ST_DONE;
        canmove_d = ~att_fail;
        new_x_d   = (att_fail && (kick_q != 2'd0)) ? base_x_q : cand_x;
        new_y_d   = (att_fail && (kick_q != 2'd0)) ? base_y_q : cand_y;
      end
`else
      state_d   = ST_DONE;
      canmove_d = ~att_fail;
      new_x_d   = cand_x;
      new_y_d   = cand_y;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      k_q       <= 2'd0;
      fail_q    <= 1'b0;
      canmove_q <= 1'b0;
      rd_q      <= '0;
      new_x_q   <= '0;
      new_y_q   <= '0;
`ifdef WALL_KICK_EN
      kick_q    <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      fail_q    <= fail_d;
      canmove_q <= canmove_d;
      rd_q      <= rd_d;
      new_x_q   <= new_x_d;
      new_y_q   <= new_y_d;
`ifdef WALL_KICK_EN
      kick_q    <= kick_d;
`endif
    end
  end

  // Request operands and targets: captured on accept / CALC, not reset.
  always_ff @(posedge Clk) begin
    if (accept) begin
      cmd_q   <= cmd_e'(cmd);
      shape_q <= shape;
      cur_x_q <= {cur_x3, cur_x2, cur_x1, cur_x0};
      cur_y_q <= {cur_y3, cur_y2, cur_y1, cur_y0};
    end
    if (state_q == ST_CALC) begin
      tgt_x_q <= tx_c;
      tgt_y_q <= ty_c;
    end
`ifdef WALL_KICK_EN
    if ((state_q == ST_CALC) && (kick_q == 2'd0)) begin
      base_x_q <= tx_c;
      base_y_q <= ty_c;
    end
`endif
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign canmove      = canmove_q;
  assign blocked_down = done && !canmove_q && (cmd_q == CMD_DOWN);
  assign rd_x         = rd_q.x;
  assign rd_y         = rd_q.y;
  assign {new_x3, new_x2, new_x1, new_x0} = new_x_q;
  assign {new_y3, new_y2, new_y1, new_y0} = new_y_q;

endmodule

// File: tb/tb_piece_mover.sv
// Directed bench for piece_mover: hand-computed targets, latencies and flags
// against a small synchronous board RAM model.
module tb_piece_mover;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [2:0] shape;
  logic [4:0] cur_x0, cur_x1, cur_x2, cur_x3;
  logic [5:0] cur_y0, cur_y1, cur_y2, cur_y3;
  logic [4:0] rd_x;
  logic [5:0] rd_y;
  logic       rd_occ;
  logic       done, canmove, blocked_down;
  logic [4:0] new_x0, new_x1, new_x2, new_x3;
  logic [5:0] new_y0, new_y1, new_y2, new_y3;

  bit   [199:0] board;
  logic [7:0]   idx;
  int checks = 0;
  int errors = 0;
  int lat;
  bit seen;
  bit any_done;

  piece_mover dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .shape(shape),
    .cur_x0(cur_x0), .cur_x1(cur_x1), .cur_x2(cur_x2), .cur_x3(cur_x3),
    .cur_y0(cur_y0), .cur_y1(cur_y1), .cur_y2(cur_y2), .cur_y3(cur_y3),
    .rd_x(rd_x), .rd_y(rd_y), .rd_occ(rd_occ),
    .done(done), .canmove(canmove), .blocked_down(blocked_down),
    .new_x0(new_x0), .new_x1(new_x1), .new_x2(new_x2), .new_x3(new_x3),
    .new_y0(new_y0), .new_y1(new_y1), .new_y2(new_y2), .new_y3(new_y3)
  );

  always #10 Clk = ~Clk;

  assign idx = 8'(rd_y) * 8'd10 + 8'(rd_x);
  always @(posedge Clk) begin
    rd_occ <= (rd_y < 6'd20 && rd_x < 5'd10) ? board[idx] : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start(input logic [1:0] c, input logic [2:0] s,
                       input logic [4:0] x0, input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] x3,
                       input logic [5:0] y0, input logic [5:0] y1, input logic [5:0] y2, input logic [5:0] y3);
    @(negedge Clk);
    cmd = c; shape = s;
    cur_x0 = x0; cur_x1 = x1; cur_x2 = x2; cur_x3 = x3;
    cur_y0 = y0; cur_y1 = y1; cur_y2 = y2; cur_y3 = y3;
    cmd_valid = 1'b1;
    @(posedge Clk); #1;
    // Scramble operands after acceptance; the DUT must use its latched copy.
    cmd_valid = 1'b0;
    cmd = 2'd0; shape = 3'd0;
    cur_x0 = 5'd31; cur_x1 = 5'd31; cur_x2 = 5'd31; cur_x3 = 5'd31;
    cur_y0 = 6'd63; cur_y1 = 6'd63; cur_y2 = 6'd63; cur_y3 = 6'd63;
  endtask

  task automatic wait_done();
    lat  = 1;
    seen = 1'b0;
    while (!done && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
      if (rd_x == 5'd5 && rd_y == 6'd10) seen = 1'b1;
    end
  endtask

  task automatic ready_next();
    @(posedge Clk); #1;
    check("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; shape = 3'd0;
    cur_x0 = 0; cur_x1 = 0; cur_x2 = 0; cur_x3 = 0;
    cur_y0 = 0; cur_y1 = 0; cur_y2 = 0; cur_y3 = 0;
    board = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;

    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_canmove", canmove, 0);
    check("rst_rd", {rd_x, rd_y}, 0);
    check("rst_new", {new_x0, new_y3}, 0);

    // 1: I piece LEFT on empty board
    start(2'd0, 3'd0, 5'd3, 5'd4, 5'd5, 5'd6, 6'd0, 6'd0, 6'd0, 6'd0);
    check("t1_busy", cmd_ready, 0);
    wait_done();
    check("t1_lat", lat, 7);
    check("t1_canmove", canmove, 1);
    check("t1_new_x", {new_x0, new_x1, new_x2, new_x3}, {5'd2, 5'd3, 5'd4, 5'd5});
    check("t1_new_y", {new_y0, new_y1, new_y2, new_y3}, 0);
    check("t1_blocked", blocked_down, 0);
    ready_next();

    // 2: LEFT against the left wall
    start(2'd0, 3'd0, 5'd0, 5'd1, 5'd2, 5'd3, 6'd0, 6'd0, 6'd0, 6'd0);
    wait_done();
    check("t2_lat", lat, 2);
    check("t2_canmove", canmove, 0);
    check("t2_rd_hold", {rd_x, rd_y}, {5'd5, 6'd0});
    check("t2_blocked", blocked_down, 0);
    ready_next();

    // 3: O piece DOWN at the floor
    start(2'd2, 3'd1, 5'd4, 5'd5, 5'd4, 5'd5, 6'd18, 6'd18, 6'd19, 6'd19);
    wait_done();
    check("t3_lat", lat, 2);
    check("t3_canmove", canmove, 0);
    check("t3_blocked", blocked_down, 1);
    ready_next();

    // 4: DOWN onto occupied (5,10)
    board[10*10 + 5] = 1'b1;
    start(2'd2, 3'd0, 5'd3, 5'd4, 5'd5, 5'd6, 6'd9, 6'd9, 6'd9, 6'd9);
    wait_done();
    check("t4_lat", lat, 7);
    check("t4_probe_seen", seen, 1);
    check("t4_canmove", canmove, 0);
    check("t4_blocked", blocked_down, 1);
    check("t4_new_y", {new_y0, new_y3}, {6'd10, 6'd10});
    ready_next();

    // RIGHT up to the last legal column, then past it
    start(2'd1, 3'd0, 5'd5, 5'd6, 5'd7, 5'd8, 6'd3, 6'd3, 6'd3, 6'd3);
    wait_done();
    check("right_lat", lat, 7);
    check("right_canmove", canmove, 1);
    check("right_new_x", {new_x0, new_x3}, {5'd6, 5'd9});
    ready_next();
    start(2'd1, 3'd0, 5'd6, 5'd7, 5'd8, 5'd9, 6'd3, 6'd3, 6'd3, 6'd3);
    wait_done();
    check("right_wall_lat", lat, 2);
    check("right_wall_canmove", canmove, 0);
    ready_next();

    // 5: T piece rotate about (5,5)
    start(2'd3, 3'd2, 5'd4, 5'd5, 5'd6, 5'd5, 6'd5, 6'd5, 6'd5, 6'd4);
    wait_done();
    check("t5_lat", lat, 7);
    check("t5_canmove", canmove, 1);
    check("t5_new_x", {new_x0, new_x1, new_x2, new_x3}, {5'd5, 5'd5, 5'd5, 5'd6});
    check("t5_new_y", {new_y0, new_y1, new_y2, new_y3}, {6'd4, 6'd5, 6'd6, 6'd5});
    ready_next();

    // 5b: O piece rotate is identity
    start(2'd3, 3'd1, 5'd4, 5'd5, 5'd4, 5'd5, 6'd4, 6'd4, 6'd5, 6'd5);
    wait_done();
    check("t5o_lat", lat, 7);
    check("t5o_canmove", canmove, 1);
    check("t5o_new", {new_x0, new_x1, new_x2, new_x3, new_y0, new_y1, new_y2, new_y3},
          {5'd4, 5'd5, 5'd4, 5'd5, 6'd4, 6'd4, 6'd5, 6'd5});
    ready_next();

    // 6: reset in cycle 4 (mid-probe)
    start(2'd0, 3'd0, 5'd3, 5'd4, 5'd5, 5'd6, 6'd2, 6'd2, 6'd2, 6'd2);
    repeat (3) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("t6_ready", cmd_ready, 1);
    check("t6_done", done, 0);
    check("t6_canmove", canmove, 0);
    check("t6_rd", {rd_x, rd_y}, 0);
    check("t6_new", {new_x0, new_x1, new_x2, new_x3, new_y0, new_y1, new_y2, new_y3}, 0);
    any_done = 1'b0;
    repeat (8) begin
      @(posedge Clk); #1;
      if (done) any_done = 1'b1;
    end
    check("t6_no_done", any_done, 0);
    start(2'd0, 3'd0, 5'd3, 5'd4, 5'd5, 5'd6, 6'd2, 6'd2, 6'd2, 6'd2);
    wait_done();
    check("t6_fresh_lat", lat, 7);
    check("t6_fresh_canmove", canmove, 1);
    check("t6_fresh_new", {new_x0, new_x1, new_x2, new_x3, new_y0, new_y3},
          {5'd2, 5'd3, 5'd4, 5'd5, 6'd2, 6'd2});
    ready_next();

`ifdef WALL_KICK_EN
    // Vertical I at the right wall: first attempt off-board, x-1 shift fits.
    start(2'd3, 3'd0, 5'd9, 5'd9, 5'd9, 5'd9, 6'd5, 6'd6, 6'd7, 6'd8);
    wait_done();
    check("kick_lat", lat, 8);
    check("kick_canmove", canmove, 1);
    check("kick_new_x", {new_x0, new_x1, new_x2, new_x3}, {5'd9, 5'd8, 5'd7, 5'd6});
    check("kick_new_y", {new_y0, new_y3}, {6'd6, 6'd6});
    ready_next();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
